serial_deserializer_16bit: RTL and testbench
============================================

Name: serial_deserializer_16bit

Overview:
Receive-side counterpart of the team's 16-bit shift/load register. Accepts a qualified serial bit stream, MSB-first or LSB-first per word, and reassembles 16-bit words. Presents each word on a one-entry valid/ready output buffer. Sits between a serial link or shift-out source and a parallel consumer.

Parameters:
WIDTH, 16, word length in bits; the design is verified at 16 only.
CNT_W, $clog2(WIDTH)+1 (=5), width of the bit counter and of bit_count; derived, not overridden.

Ports:
clk  in  1  single clock; all state updates on posedge.
rst_n  in  1  asynchronous, active-low reset.
clear  in  1  synchronous flush of the partial word and the sticky overrun flag.
msb_first  in  1  1 = MSB-first word, 0 = LSB-first; sampled at the first bit of each word.
ser_in  in  1  serial data bit.
ser_valid  in  1  ser_in is qualified this cycle.
data_out  out  16  assembled word, held while data_valid = 1.
data_valid  out  1  output buffer holds an unconsumed word.
data_ready  in  1  consumer accepts data_out when data_valid & data_ready.
bit_count  out  5  bits collected toward the current word, 0..15.
overrun  out  1  sticky: a completed word was dropped because the buffer was full.

Behaviour:
- Reset (rst_n = 0, asynchronous): shift reg = 0; bit_count = 0; latched mode = 1 (MSB-first); data_out = 16'h0000; data_valid = 0; overrun = 0.
- Priority each cycle: reset > clear > ser_valid.
- Accept a bit on ser_valid = 1:
  - When bit_count == 0, latch msb_first as the word mode. The word mode is used for all 16 bits of that word. Changes to msb_first mid-word are ignored.
  - MSB-first: sh <= {sh[14:0], ser_in}. First bit ends up in bit 15.
  - LSB-first: sh <= {ser_in, sh[15:1]}. First bit ends up in bit 0.
  - bit_count increments.
- Word completion: ser_valid with bit_count == 15.
  - The word is the post-shift value. bit_count wraps to 0.
  - Buffer is free if data_valid == 0, or data_valid & data_ready this cycle. If free: data_out <= word and data_valid <= 1 next cycle. Latency is 1 clock after the 16th bit's edge.
  - Buffer not free: word is dropped, data_out and data_valid are unchanged, overrun <= 1.
- Handshake:
  - data_valid & data_ready with no simultaneous completion: data_valid <= 0. data_out keeps its last value.
  - Accept and completion in the same cycle: the new word replaces the old one and data_valid stays 1. This gives back-to-back throughput of one word per 16 bits.
  - data_out must be stable while data_valid = 1 and data_ready = 0.
- clear:
  - Resets sh, bit_count, latched mode and overrun.
  - Does not touch data_out or data_valid.
  - clear together with ser_valid: the bit is discarded.
  - clear with bit_count == 15 and ser_valid: no word is produced.
- No ser_valid: all state holds. Gaps between bits are unlimited.
- Reset mid-word or with data_valid = 1: everything returns to reset values, and the pending word is lost.

Decomposition:
- Package serdes_pkg holds: WIDTH = 16; CNT_W; typedef enum logic {LSB_FIRST = 0, MSB_FIRST = 1} bit_order_t. A future matching serializer reuses this package.
- One sub-module, deser_out_buf: the one-entry valid/ready holding register plus overrun detection.
  - Inputs: word, word_done, data_ready, clear.
  - Outputs: data_out, data_valid, overrun.
  - The top keeps the shift register, counter and mode latch.

Test Plan:
- MSB-first, data_ready = 1, serial bits of 16'hA5C3 sent MSB first on consecutive cycles -> data_out = 16'hA5C3 and data_valid = 1 for one cycle, starting the cycle after bit 16; bit_count = 0.
- LSB-first, same bit sequence as test 1 -> data_out = 16'hC3A5; msb_first toggled after bit 3 changes nothing.
- data_ready = 0; words 16'h1234 then 16'hBEEF -> data_out holds 16'h1234, data_valid = 1, overrun = 1 after the second word's 16th bit. Then data_ready = 1 for one cycle -> data_valid = 0, and overrun stays 1 until clear.
- data_ready = 1 and second word completes in the cycle the first is accepted -> data_valid stays 1 and data_out changes directly 16'h1234 -> 16'hBEEF; no overrun.
- Sequence: 7 bits sent, then clear with ser_valid = 1, then 16 bits of 16'h00FF -> bit_count = 0 after clear; output = 16'h00FF (not shifted by the 7 stale bits); data_out/data_valid unchanged by the clear.
- rst_n pulsed low asynchronously between edges mid-word with data_valid = 1 -> all outputs 0 immediately. The next full word 16'h8001 is received correctly MSB-first.

Source files
------------

// File: rtl/serdes_pkg.sv
// Shared constants and types for the serial (de)serializer family.
// Word length, counter width and the bit-order encoding live here.
package serdes_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {
    LSB_FIRST = 1'b0,
    MSB_FIRST = 1'b1
  } bit_order_t;

endpackage

// File: rtl/deser_out_buf.sv
// One-entry valid/ready holding register for assembled words.
// Flags a sticky overrun when a completed word finds the buffer occupied.
module deser_out_buf
  import serdes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] word,
  input  logic             word_done,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             over_q, over_d;
  logic             buf_free;

  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    over_d   = over_q;
    // Accepting the old word this cycle frees the slot for a new one.
    buf_free = ~valid_q | data_ready;
    if (word_done) begin
      if (buf_free) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        over_d = 1'b1;
      end
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
    if (clear) begin
      over_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      over_q  <= over_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overrun    = over_q;

endmodule

// File: rtl/serial_deserializer_16bit.sv
// Serial-to-parallel receiver: collects qualified bits MSB- or LSB-first
// per word and hands each completed word to a one-entry output buffer.
module serial_deserializer_16bit
  import serdes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             msb_first,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun
);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  bit_order_t       mode_q, mode_d, word_mode;
  logic             accept;
  logic             word_done;

  always_comb begin
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    // The order is taken from the pin only on the first bit of a word.
    word_mode = (cnt_q == '0) ? bit_order_t'(msb_first) : mode_q;
    accept    = ser_valid & ~clear;
    word_done = accept & (cnt_q == CNT_W'(WIDTH - 1));
    if (clear) begin
      sh_d   = '0;
      cnt_d  = '0;
      mode_d = MSB_FIRST;
    end else if (ser_valid) begin
      mode_d = word_mode;
      if (word_mode == MSB_FIRST) begin
        sh_d = {sh_q[WIDTH-2:0], ser_in};
      end else begin
        sh_d = {ser_in, sh_q[WIDTH-1:1]};
      end
      cnt_d = word_done ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      cnt_q  <= '0;
      mode_q <= MSB_FIRST;
    end else begin
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
    end
  end

  deser_out_buf u_out_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .word       (sh_d),
    .word_done  (word_done),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .overrun    (overrun)
  );

  assign bit_count = cnt_q;

endmodule

// File: tb/tb_serial_deserializer_16bit.sv
// Self-checking bench for serial_deserializer_16bit: directed scenarios plus
// a randomized run scored against a queue-based word-assembly model.
module tb_serial_deserializer_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        msb_first;
  logic        ser_in;
  logic        ser_valid;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic [4:0]  bit_count;
  logic        overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          q_bits[$];
  bit          m_msb;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_over;

  always #5 clk = ~clk;

  serial_deserializer_16bit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .msb_first  (msb_first),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .bit_count  (bit_count),
    .overrun    (overrun)
  );

  function automatic logic [15:0] assemble(input bit msb);
    int unsigned w = 0;
    for (int i = 0; i < 16; i++) begin
      if (msb) w = w + (int'(q_bits[i]) << (15 - i));
      else     w = w + (int'(q_bits[i]) << i);
    end
    return w[15:0];
  endfunction

  task automatic model_reset();
    q_bits.delete();
    m_msb   = 1'b1;
    m_data  = 16'h0000;
    m_valid = 1'b0;
    m_over  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance one clock, update the model, settle.
  task automatic step(input logic sv, input logic b, input logic ms, input logic rdy,
                      input logic clr);
    logic        done;
    logic [15:0] w;
    ser_valid  = sv;
    ser_in     = b;
    msb_first  = ms;
    data_ready = rdy;
    clear      = clr;
    @(posedge clk);
    done = 1'b0;
    w    = 16'h0;
    if (clr) begin
      q_bits.delete();
      m_over = 1'b0;
    end else if (sv) begin
      if (q_bits.size() == 0) m_msb = ms;
      q_bits.push_back(b);
      if (q_bits.size() == 16) begin
        w    = assemble(m_msb);
        done = 1'b1;
        q_bits.delete();
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_data  = w;
        m_valid = 1'b1;
      end else begin
        m_over = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic send_word(input logic [15:0] w, input logic ms, input logic rdy);
    for (int i = 0; i < 16; i++) step(1'b1, w[15-i], ms, rdy, 1'b0);
  endtask

  task automatic test_reset();
    n_checks += 4;
    if (data_out !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h want 0000", data_out); end
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    if (bit_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bit_count); end
  endtask

  task automatic test_msb_first();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 16'hA5C3 >> (15 - i), 1'b1, 1'b1, 1'b0);
      if (i < 15) begin
        n_checks++;
        if (bit_count !== 5'(i + 1)) begin
          n_fail++; $display("FAIL msb_count: got %0d want %0d", bit_count, i + 1);
        end
      end
    end
    n_checks += 3;
    if (data_out !== 16'hA5C3) begin n_fail++; $display("FAIL msb_data: got %h want a5c3", data_out); end
    if (data_valid !== 1'b1) begin n_fail++; $display("FAIL msb_valid: got %b want 1", data_valid); end
    if (bit_count !== 5'd0) begin n_fail++; $display("FAIL msb_wrap: got %0d want 0", bit_count); end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks += 2;
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL msb_one_cycle: got %b want 0", data_valid); end
    if (data_out !== 16'hA5C3) begin n_fail++; $display("FAIL msb_hold: got %h want a5c3", data_out); end
  endtask

  task automatic test_lsb_first();
    logic [15:0] seq = 16'hA5C3;
    for (int i = 0; i < 16; i++) step(1'b1, seq[15-i], (i < 3) ? 1'b0 : 1'b1, 1'b1, 1'b0);
    n_checks += 2;
    if (data_out !== 16'hC3A5) begin n_fail++; $display("FAIL lsb_data: got %h want c3a5", data_out); end
    if (data_valid !== 1'b1) begin n_fail++; $display("FAIL lsb_valid: got %b want 1", data_valid); end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_overrun();
    send_word(16'h1234, 1'b1, 1'b0);
    send_word(16'hBEEF, 1'b1, 1'b0);
    n_checks += 3;
    if (data_out !== 16'h1234) begin n_fail++; $display("FAIL ovr_data: got %h want 1234", data_out); end
    if (data_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b want 1", data_valid); end
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks += 2;
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: got %b want 0", data_valid); end
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w2 = 16'hBEEF;
    send_word(16'h1234, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step(1'b1, w2[15-i], 1'b1, 1'b0, 1'b0);
      n_checks++;
      if (data_out !== 16'h1234 || data_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_stable: got %h/%b want 1234/1", data_out, data_valid);
      end
    end
    step(1'b1, w2[0], 1'b1, 1'b1, 1'b0);
    n_checks += 3;
    if (data_out !== 16'hBEEF) begin n_fail++; $display("FAIL b2b_data: got %h want beef", data_out); end
    if (data_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", data_valid); end
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_clear();
    send_word(16'h1234, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom), 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    n_checks += 3;
    if (bit_count !== 5'd0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", bit_count); end
    if (data_out !== 16'h1234) begin n_fail++; $display("FAIL clr_data: got %h want 1234", data_out); end
    if (data_valid !== 1'b1) begin n_fail++; $display("FAIL clr_valid: got %b want 1", data_valid); end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_word(16'h00FF, 1'b1, 1'b1);
    n_checks += 2;
    if (data_out !== 16'h00FF) begin n_fail++; $display("FAIL clr_word: got %h want 00ff", data_out); end
    if (data_valid !== 1'b1) begin n_fail++; $display("FAIL clr_word_valid: got %b want 1", data_valid); end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    send_word(16'h1234, 1'b1, 1'b0);
    send_word(16'h5678, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    ser_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks += 4;
    if (data_out !== 16'h0000) begin n_fail++; $display("FAIL ares_data: got %h want 0000", data_out); end
    if (data_valid !== 1'b0) begin n_fail++; $display("FAIL ares_valid: got %b want 0", data_valid); end
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL ares_overrun: got %b want 0", overrun); end
    if (bit_count !== 5'd0) begin n_fail++; $display("FAIL ares_count: got %0d want 0", bit_count); end
    #1 rst_n = 1'b1;
    model_reset();
    send_word(16'h8001, 1'b1, 1'b1);
    n_checks += 2;
    if (data_out !== 16'h8001) begin n_fail++; $display("FAIL ares_word: got %h want 8001", data_out); end
    if (data_valid !== 1'b1) begin n_fail++; $display("FAIL ares_word_valid: got %b want 1", data_valid); end
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
           $urandom_range(0, 99) == 0);
      n_checks += 4;
      if (data_out !== m_data) begin
        n_fail++; $display("FAIL rnd_data: cycle %0d got %h want %h", n, data_out, m_data);
      end
      if (data_valid !== m_valid) begin
        n_fail++; $display("FAIL rnd_valid: cycle %0d got %b want %b", n, data_valid, m_valid);
      end
      if (overrun !== m_over) begin
        n_fail++; $display("FAIL rnd_overrun: cycle %0d got %b want %b", n, overrun, m_over);
      end
      if (bit_count !== 5'(q_bits.size())) begin
        n_fail++; $display("FAIL rnd_count: cycle %0d got %0d want %0d", n, bit_count, q_bits.size());
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    msb_first  = 1'b1;
    ser_in     = 1'b0;
    ser_valid  = 1'b0;
    data_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
